// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller:
// state enum, opcode/funct constants, datapath select codes and the per-state control decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
        logic       pcSrc;
        logic [2:0] aluControl;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       regWrite;
        logic       iorD;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       retire;
    } ctrl_t;

    // Control word for a state; execAlu only matters for EXECUTE.
    function automatic ctrl_t ctrlForState(input state_t s, input logic [2:0] execAlu);
        ctrl_t c;
        c            = '0;
        c.aluControl = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.aluSrcB = SRCB_FOUR;
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
            end
            S_DECODE:  c.aluSrcB = SRCB_IMMSH;
            S_MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            S_MEMRD:   c.iorD = 1'b1;
            S_MEMWB: begin
                c.memtoReg = 1'b1;
                c.regWrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_MEMWR: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_EXECUTE: begin
                c.aluSrcA    = 1'b1;
                c.aluSrcB    = SRCB_REG;
                c.aluControl = execAlu;
            end
            S_ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA    = 1'b1;
                c.aluSrcB    = SRCB_REG;
                c.aluControl = ALU_SUB;
                c.pcSrc      = 1'b1;
                c.branch     = 1'b1;
                c.retire     = 1'b1;
            end
            S_ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                c.regWrite = 1'b1;
                c.retire   = 1'b1;
            end
            default: c.aluControl = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the main controller and the multicycle datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       PCWrite;
    logic       Branch;
    logic       PCSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [3:0] state_o;
    logic       retire;
    logic       illegal;

    modport master (
        input  Op, Funct,
        output PCWrite, Branch, PCSrc, ALUControl, ALUSrcB, ALUSrcA, RegWrite,
               IorD, MemWrite, IRWrite, RegDst, MemtoReg, state_o, retire, illegal
    );

    modport slave (
        output Op, Funct,
        input  PCWrite, Branch, PCSrc, ALUControl, ALUSrcB, ALUSrcA, RegWrite,
               IorD, MemWrite, IRWrite, RegDst, MemtoReg, state_o, retire, illegal
    );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU operation plus a legality flag for the supported funct set.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_aluControl,
    output logic       o_functLegal
);

    always_comb begin
        o_aluControl = ALU_ADD;
        o_functLegal = 1'b1;
        case (i_funct)
            FN_ADD:  o_aluControl = ALU_ADD;
            FN_SUB:  o_aluControl = ALU_SUB;
            FN_AND:  o_aluControl = ALU_AND;
            FN_OR:   o_aluControl = ALU_OR;
            FN_SLT:  o_aluControl = ALU_SLT;
            default: o_functLegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller (Moore FSM) with retire pulse, illegal-instruction
// detection and optional halt-on-illegal trap.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_fsm_if.master  bus
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic [2:0] w_aluControl;
    logic       w_functLegal;
    logic       w_instrLegal;

    mc_alu_dec u_aluDec (
        .i_funct      (bus.Funct),
        .o_aluControl (w_aluControl),
        .o_functLegal (w_functLegal)
    );

    always_comb begin
        case (bus.Op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_instrLegal = 1'b1;
            OP_RTYPE:                      w_instrLegal = w_functLegal;
            default:                       w_instrLegal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                if (!w_instrLegal) begin
                    w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end else begin
                    case (bus.Op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_ADDI:      w_next = S_ADDIEX;
                        default:      w_next = S_EXECUTE;
                    endcase
                end
            end
            S_MEMADR:  w_next = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state, so it is decoded for the
    // state being entered; the EXECUTE ALU op is latched from Funct while in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrlForState(S_FETCH, ALU_ADD);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrlForState(w_next, w_aluControl);
        end
    end

    assign bus.PCWrite    = r_ctrl.pcWrite  & ~rst;
    assign bus.Branch     = r_ctrl.branch   & ~rst;
    assign bus.IRWrite    = r_ctrl.irWrite  & ~rst;
    assign bus.MemWrite   = r_ctrl.memWrite & ~rst;
    assign bus.RegWrite   = r_ctrl.regWrite & ~rst;
    assign bus.retire     = r_ctrl.retire   & ~rst;
    assign bus.PCSrc      = r_ctrl.pcSrc;
    assign bus.ALUControl = r_ctrl.aluControl;
    assign bus.ALUSrcB    = r_ctrl.aluSrcB;
    assign bus.ALUSrcA    = r_ctrl.aluSrcA;
    assign bus.IorD       = r_ctrl.iorD;
    assign bus.RegDst     = r_ctrl.regDst;
    assign bus.MemtoReg   = r_ctrl.memtoReg;
    assign bus.state_o    = r_state;
    assign bus.illegal    = ~rst & (r_state == S_DECODE) & ~w_instrLegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: two instances (trap off / trap on) driven with the same
// instruction stream and checked every cycle against an instruction-level model.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pcw;
        logic       br;
        logic       pcs;
        logic [2:0] alu;
        logic [1:0] srcb;
        logic       srca;
        logic       rw;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       ret;
    } tbctl_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] RTY  = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] tbOp = LW;
    logic [5:0] tbFunct = 6'd0;
    int         pos = 0;
    bit         halted = 1'b0;
    bit         resetSeen = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if busA ();
    mc_ctrl_fsm_if busB ();

    assign busA.Op    = tbOp;
    assign busA.Funct = tbFunct;
    assign busB.Op    = tbOp;
    assign busB.Funct = tbFunct;

    mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b0)) dutA (.clk(clk), .rst(rst), .bus(busA.master));
    mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) dutB (.clk(clk), .rst(rst), .bus(busB.master));

    // ---------------- behavioural model ----------------
    function automatic bit functOk(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic bit isLegal(input logic [5:0] op, input logic [5:0] f);
        if (op == RTY) return functOk(f);
        return op == LW || op == SW || op == BEQ || op == ADDI;
    endfunction

    function automatic logic [2:0] functAlu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int instLen(input logic [5:0] op, input logic [5:0] f);
        if (!isLegal(op, f)) return 2;
        case (op)
            LW:      return 5;
            BEQ:     return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int instState(input logic [5:0] op, input logic [5:0] f, input int p);
        int lwS[5] = '{0, 1, 2, 3, 4};
        int swS[4] = '{0, 1, 2, 5};
        int rS[4]  = '{0, 1, 6, 7};
        int bS[3]  = '{0, 1, 8};
        int aS[4]  = '{0, 1, 9, 10};
        if (p == 0) return 0;
        if (p == 1) return 1;
        if (!isLegal(op, f)) return 0;
        case (op)
            LW:      return lwS[p];
            SW:      return swS[p];
            BEQ:     return bS[p];
            ADDI:    return aS[p];
            default: return rS[p];
        endcase
    endfunction

    function automatic tbctl_t expOut(input int st, input logic [5:0] f, input logic r);
        tbctl_t e;
        e     = '0;
        e.alu = 3'b010;
        case (st)
            0:  begin e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1; end
            1:  e.srcb = 2'b11;
            2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.m2r = 1'b1; e.rw = 1'b1; e.ret = 1'b1; end
            5:  begin e.iord = 1'b1; e.mw = 1'b1; e.ret = 1'b1; end
            6:  begin e.srca = 1'b1; e.alu = functAlu(f); end
            7:  begin e.rdst = 1'b1; e.rw = 1'b1; e.ret = 1'b1; end
            8:  begin e.srca = 1'b1; e.alu = 3'b110; e.pcs = 1'b1; e.br = 1'b1; e.ret = 1'b1; end
            9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            10: begin e.rw = 1'b1; e.ret = 1'b1; end
            default: e.alu = 3'b010;
        endcase
        if (r) begin
            e.pcw = 1'b0; e.br = 1'b0; e.irw = 1'b0;
            e.mw  = 1'b0; e.rw = 1'b0; e.ret = 1'b0;
        end
        return e;
    endfunction

    task automatic modelEdge();
        if (rst) begin
            pos       = 0;
            halted    = 1'b0;
            resetSeen = 1'b1;
        end else begin
            if (!halted && pos == 1 && !isLegal(tbOp, tbFunct)) halted = 1'b1;
            pos++;
            if (pos >= instLen(tbOp, tbFunct)) pos = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input tbctl_t act, input logic [3:0] actSt,
                               input logic actIll, input int expSt);
        tbctl_t e;
        logic   expIll;
        e      = expOut(expSt, tbFunct, rst);
        expIll = (expSt == 1) && !isLegal(tbOp, tbFunct) && !rst;
        checks += 3;
        if (int'(actSt) != expSt) begin
            errors++;
            $display("[TB] FAIL %s.state t=%0t got %0d expected %0d", name, $time, actSt, expSt);
        end
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s.ctrl t=%0t state %0d got %h expected %h", name, $time, expSt, act, e);
        end
        if (actIll !== expIll) begin
            errors++;
            $display("[TB] FAIL %s.illegal t=%0t got %b expected %b", name, $time, actIll, expIll);
        end
    endtask

    task automatic checkLiteral(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetSeen) begin
            int sA;
            sA = instState(tbOp, tbFunct, pos);
            checkOutput("A", {busA.PCWrite, busA.Branch, busA.PCSrc, busA.ALUControl, busA.ALUSrcB,
                              busA.ALUSrcA, busA.RegWrite, busA.IorD, busA.MemWrite, busA.IRWrite,
                              busA.RegDst, busA.MemtoReg, busA.retire},
                        busA.state_o, busA.illegal, sA);
            checkOutput("B", {busB.PCWrite, busB.Branch, busB.PCSrc, busB.ALUControl, busB.ALUSrcB,
                              busB.ALUSrcA, busB.RegWrite, busB.IorD, busB.MemWrite, busB.IRWrite,
                              busB.RegDst, busB.MemtoReg, busB.retire},
                        busB.state_o, busB.illegal, halted ? 11 : sA);
        end
    end

    // ---------------- stimulus ----------------
    // Runs one instruction from FETCH back to FETCH, tracing dutA's states (one hex digit each).
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] f,
                                 output logic [31:0] trace, output int retires, output int illegals,
                                 output logic [2:0] execAlu, output logic [3:0] fetchCtl,
                                 output logic bEnables);
        int guard;
        guard    = 0;
        tbOp     = op;
        tbFunct  = f;
        trace    = '0;
        retires  = 0;
        illegals = 0;
        execAlu  = 3'b000;
        fetchCtl = 4'h0;
        bEnables = 1'b0;
        do begin
            @(negedge clk); #1;
            trace = (trace << 4) | 32'(busA.state_o);
            if (busA.retire)  retires++;
            if (busA.illegal) illegals++;
            if (busA.state_o == 4'd6) execAlu = busA.ALUControl;
            if (guard == 0) fetchCtl = {busA.IRWrite, busA.PCWrite, busA.ALUSrcB};
            bEnables |= busB.PCWrite | busB.Branch | busB.IRWrite | busB.MemWrite | busB.RegWrite;
            tick();
            guard++;
        end while (pos != 0 && guard < 10);
        if (guard >= 10) begin
            errors++;
            $display("[TB] FAIL timeout instr op=%b", op);
        end
    endtask

    task automatic pickRandom();
        logic [5:0] fnList[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] badOps[4] = '{6'b111111, 6'b000010, 6'b100000, 6'b001101};
        int k;
        k       = $urandom_range(0, 9);
        tbFunct = 6'($urandom);
        case (k)
            0, 1:    tbOp = LW;
            2:       tbOp = SW;
            3, 4: begin tbOp = RTY; tbFunct = fnList[$urandom_range(0, 4)]; end
            5:       tbOp = BEQ;
            6:       tbOp = ADDI;
            7:       tbOp = RTY;
            8:       tbOp = badOps[$urandom_range(0, 3)];
            default: tbOp = 6'($urandom);
        endcase
    endtask

    initial begin
        logic [31:0] tr;
        int          rets;
        int          ills;
        logic [2:0]  ex;
        logic [3:0]  fc;
        logic        be;
        logic        rwSeen;
        int          guard;
        int          rstHold;

        $display("[TB] start");
        repeat (3) tick();
        @(negedge clk); #1;
        checkLiteral("rst.state", 32'(busA.state_o), 32'd0);
        checkLiteral("rst.enables", 32'({busA.PCWrite, busA.IRWrite, busA.MemWrite, busA.RegWrite,
                                         busA.Branch, busA.retire, busA.illegal}), 32'd0);
        tick();
        rst = 1'b0;

        applyStimulus(LW, 6'd0, tr, rets, ills, ex, fc, be);
        checkLiteral("postRst.fetch", 32'(fc), 32'b1101);
        checkLiteral("lw.trace", tr, 32'h01234);
        checkLiteral("lw.retire", 32'(rets), 32'd1);

        applyStimulus(SW, 6'd7, tr, rets, ills, ex, fc, be);
        checkLiteral("sw.trace", tr, 32'h0125);
        checkLiteral("sw.retire", 32'(rets), 32'd1);

        applyStimulus(RTY, 6'b100010, tr, rets, ills, ex, fc, be);
        checkLiteral("sub.trace", tr, 32'h0167);
        checkLiteral("sub.alu", 32'(ex), 32'b110);
        applyStimulus(RTY, 6'b101010, tr, rets, ills, ex, fc, be);
        checkLiteral("slt.alu", 32'(ex), 32'b111);
        applyStimulus(RTY, 6'b100101, tr, rets, ills, ex, fc, be);
        checkLiteral("or.alu", 32'(ex), 32'b001);

        applyStimulus(BEQ, 6'd3, tr, rets, ills, ex, fc, be);
        checkLiteral("beq.trace", tr, 32'h018);
        applyStimulus(ADDI, 6'd9, tr, rets, ills, ex, fc, be);
        checkLiteral("addi.trace", tr, 32'h019A);

        applyStimulus(6'b111111, 6'd0, tr, rets, ills, ex, fc, be);
        checkLiteral("ill.trace", tr, 32'h01);
        checkLiteral("ill.pulse", 32'(ills), 32'd1);
        checkLiteral("ill.retire", 32'(rets), 32'd0);

        applyStimulus(LW, 6'd0, tr, rets, ills, ex, fc, be);
        checkLiteral("halt.en1", 32'(be), 32'd0);
        applyStimulus(SW, 6'd0, tr, rets, ills, ex, fc, be);
        checkLiteral("halt.en2", 32'(be), 32'd0);
        applyStimulus(BEQ, 6'd0, tr, rets, ills, ex, fc, be);
        checkLiteral("halt.en3", 32'(be), 32'd0);
        @(negedge clk); #1;
        checkLiteral("halt.state", 32'(busB.state_o), 32'd11);

        // reset during MEMRD of a lw must suppress the writeback
        tbOp  = LW;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (pos != 3 && guard < 10);
        checkLiteral("midRst.reachMemrd", 32'(pos), 32'd3);
        rst    = 1'b1;
        @(negedge clk); #1;
        rwSeen = busA.RegWrite;
        tick();
        rst = 1'b0;
        @(negedge clk); #1;
        rwSeen |= busA.RegWrite;
        checkLiteral("midRst.state", 32'(busA.state_o), 32'd0);
        checkLiteral("midRst.stateB", 32'(busB.state_o), 32'd0);
        checkLiteral("midRst.regWrite", 32'(rwSeen), 32'd0);

        rstHold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rstHold > 0) begin
                rst = 1'b1;
                rstHold--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 59) == 0) begin
                    rst     = 1'b1;
                    rstHold = $urandom_range(0, 2);
                end
            end
            if (pos == 0) pickRandom();
            tick();
        end
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
